// File: rtl/x2050_rmv_seq.sv
// Right mover input-select sequencer: arbitrates mpx buffer-in, CPU microword and a
// byte-stream walker onto registered MV/IO-mode/MB/LB controls with a one-clock V strobe.
module x2050_rmv_seq #(
  parameter int MPX_BURST = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cpu_req,
  input  logic [1:0] i_cpu_mv,
  input  logic [1:0] i_cpu_lb,
  input  logic [1:0] i_cpu_mb,
  output logic       o_cpu_stall,
  input  logic       i_str_start,
  input  logic [1:0] i_str_first,
  input  logic [1:0] i_str_last,
  output logic       o_str_busy,
  output logic       o_str_done,
  input  logic       i_mpx_valid,
  output logic       o_mpx_ready,
  output logic [1:0] o_mv,
  output logic       o_io_mode,
  output logic [1:0] o_mb,
  output logic [1:0] o_lb,
  output logic [1:0] o_grant,
  output logic       o_v_strobe
);

  localparam int CNT_W = $clog2(MPX_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MPX_BURST);

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_MPX  = 2'd1;
  localparam logic [1:0] G_CPU  = 2'd2;
  localparam logic [1:0] G_STR  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} str_state_e;

  str_state_e       str_state_q;
  logic             str_busy_q, str_done_q;
  logic [1:0]       ptr_q, last_q;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [1:0]       mv_q, mv_d;
  logic             io_q, io_d;
  logic [1:0]       mb_q, mb_d;
  logic [1:0]       lb_q, lb_d;
  logic [1:0]       grant_q, grant_d;
  logic             vstb_q;
  logic             str_req, burst_lim, mpx_win, cpu_win, str_win;

  // The burst counter holds at its limit while mpx runs alone.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == BURST_MAX) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    str_req   = (str_state_q == S_RUN);
    burst_lim = (burst_q == BURST_MAX) && (i_cpu_req || str_req);
    mpx_win   = i_mpx_valid && !burst_lim;
    cpu_win   = i_cpu_req && !mpx_win;
    str_win   = str_req && !mpx_win && !i_cpu_req;
    burst_d   = mpx_win ? sat_inc(burst_q) : '0;
  end

  assign o_mpx_ready = mpx_win;
  assign o_cpu_stall = i_cpu_req && !cpu_win;

  always_comb begin
    mv_d    = 2'd0;
    io_d    = 1'b0;
    mb_d    = mb_q;
    lb_d    = lb_q;
    grant_d = G_NONE;
    if (mpx_win) begin
      mv_d    = 2'd2;
      io_d    = 1'b1;
      grant_d = G_MPX;
    end else if (cpu_win) begin
      mv_d    = i_cpu_mv;
      mb_d    = i_cpu_mb;
      lb_d    = i_cpu_lb;
      grant_d = G_CPU;
    end else if (str_win) begin
      mv_d    = 2'd2;
      mb_d    = ptr_q;
      grant_d = G_STR;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      mv_q    <= 2'd0;
      io_q    <= 1'b0;
      mb_q    <= 2'd0;
      lb_q    <= 2'd0;
      grant_q <= G_NONE;
      vstb_q  <= 1'b0;
      burst_q <= '0;
    end else begin
      mv_q    <= mv_d;
      io_q    <= io_d;
      mb_q    <= mb_d;
      lb_q    <= lb_d;
      grant_q <= grant_d;
      vstb_q  <= (grant_d != G_NONE);
      burst_q <= burst_d;
    end
  end

  // DONE lasts exactly the clock in which the last byte's V strobe is presented.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      str_state_q <= S_IDLE;
      str_busy_q  <= 1'b0;
      str_done_q  <= 1'b0;
    end else begin
      case (str_state_q)
        S_IDLE: begin
          str_done_q <= 1'b0;
          if (i_str_start) begin
            str_state_q <= S_RUN;
            str_busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (str_win && (ptr_q == last_q)) begin
            str_state_q <= S_DONE;
            str_busy_q  <= 1'b0;
            str_done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          str_state_q <= S_IDLE;
          str_done_q  <= 1'b0;
        end
        default: begin
          str_state_q <= S_IDLE;
          str_busy_q  <= 1'b0;
          str_done_q  <= 1'b0;
        end
      endcase
    end
  end

  // Walker pointers are pure data; they are always reloaded on start.
  always_ff @(posedge i_clk) begin
    if ((str_state_q == S_IDLE) && i_str_start) begin
      ptr_q  <= i_str_first;
      last_q <= i_str_last;
    end else if (str_win) begin
      ptr_q  <= ptr_q + 2'd1;
    end
  end

  assign o_mv       = mv_q;
  assign o_io_mode  = io_q;
  assign o_mb       = mb_q;
  assign o_lb       = lb_q;
  assign o_grant    = grant_q;
  assign o_v_strobe = vstb_q;
  assign o_str_busy = str_busy_q;
  assign o_str_done = str_done_q;

endmodule

// File: tb/tb_x2050_rmv_seq.sv
// Bench for x2050_rmv_seq: directed vector table, burst/reset sequences and random
// traffic compared against a queue-based reference model of the arbiter.
module tb_x2050_rmv_seq;

  localparam int BURST = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_req, str_start, mpx_valid;
  logic [1:0] cpu_mv, cpu_lb, cpu_mb, str_first, str_last;
  logic       cpu_stall, str_busy, str_done, mpx_ready, io_mode, v_strobe;
  logic [1:0] mv, mb, lb, grant;

  x2050_rmv_seq #(.MPX_BURST(BURST)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_mv(cpu_mv), .i_cpu_lb(cpu_lb), .i_cpu_mb(cpu_mb),
    .o_cpu_stall(cpu_stall),
    .i_str_start(str_start), .i_str_first(str_first), .i_str_last(str_last),
    .o_str_busy(str_busy), .o_str_done(str_done),
    .i_mpx_valid(mpx_valid), .o_mpx_ready(mpx_ready),
    .o_mv(mv), .o_io_mode(io_mode), .o_mb(mb), .o_lb(lb),
    .o_grant(grant), .o_v_strobe(v_strobe)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // Reference model: pending stream bytes as a queue, burst count as an integer.
  int   m_q[$];
  int   m_cnt;
  bit   m_done;
  int   m_grant, m_mv, m_io, m_mb, m_lb;
  logic smp_ready, smp_stall;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_cnt = 0; m_done = 0;
    m_grant = 0; m_mv = 0; m_io = 0; m_mb = 0; m_lb = 0;
  endtask

  function automatic int model_winner(input bit mpx, input bit cpu);
    bit force_slot;
    force_slot = (m_cnt == BURST) && (cpu || (m_q.size() > 0));
    if (mpx && !force_slot) return 1;
    if (cpu) return 2;
    if (m_q.size() > 0) return 3;
    return 0;
  endfunction

  task automatic model_update(input int win, input int cmv, input int clb, input int cmb,
                              input bit st, input int fi, input int la);
    bit idle_pre;
    int p;
    idle_pre = (m_q.size() == 0) && !m_done;
    m_grant = win;
    m_done  = 0;
    case (win)
      1: begin m_mv = 2; m_io = 1; end
      2: begin m_mv = cmv; m_io = 0; m_mb = cmb; m_lb = clb; end
      3: begin
        m_mv = 2; m_io = 0; m_mb = m_q[0];
        m_done = (m_q.size() == 1);
        void'(m_q.pop_front());
      end
      default: begin m_mv = 0; m_io = 0; end
    endcase
    if (idle_pre && st) begin
      p = fi;
      forever begin
        m_q.push_back(p);
        if (p == la) break;
        p = (p + 1) % 4;
      end
    end
    m_cnt = (win == 1) ? ((m_cnt < BURST) ? m_cnt + 1 : BURST) : 0;
  endtask

  task automatic step(input logic mpx, input logic cpu, input logic [1:0] cmv,
                      input logic [1:0] clb, input logic [1:0] cmb, input logic st,
                      input logic [1:0] fi, input logic [1:0] la);
    int win;
    mpx_valid = mpx; cpu_req = cpu; cpu_mv = cmv; cpu_lb = clb; cpu_mb = cmb;
    str_start = st; str_first = fi; str_last = la;
    #3;
    win = model_winner(mpx, cpu);
    smp_ready = mpx_ready;
    smp_stall = cpu_stall;
    chk("mpx_ready", int'(smp_ready), int'(win == 1));
    chk("cpu_stall", int'(smp_stall), int'(cpu && (win != 2)));
    @(posedge clk); #1;
    model_update(win, int'(cmv), int'(clb), int'(cmb), st, int'(fi), int'(la));
    chk("grant", int'(grant), m_grant);
    chk("v_strobe", int'(v_strobe), int'(m_grant != 0));
    chk("mv", int'(mv), m_mv);
    chk("io_mode", int'(io_mode), m_io);
    chk("mb", int'(mb), m_mb);
    chk("lb", int'(lb), m_lb);
    chk("str_busy", int'(str_busy), int'(m_q.size() > 0));
    chk("str_done", int'(str_done), int'(m_done));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, int'(grant), 0);
    chk({tag, "_vstb"}, int'(v_strobe), 0);
    chk({tag, "_mv"}, int'(mv), 0);
    chk({tag, "_io"}, int'(io_mode), 0);
    chk({tag, "_mb"}, int'(mb), 0);
    chk({tag, "_lb"}, int'(lb), 0);
    chk({tag, "_busy"}, int'(str_busy), 0);
    chk({tag, "_done"}, int'(str_done), 0);
    chk({tag, "_ready"}, int'(mpx_ready), 0);
    chk({tag, "_stall"}, int'(cpu_stall), 0);
  endtask

  typedef struct {
    logic mpx, cpu; logic [1:0] mv, lb, mb; logic st; logic [1:0] fi, la;
    logic e_rdy, e_stall; logic [1:0] e_grant, e_mv; logic e_io;
    logic [1:0] e_mb, e_lb; logic e_done, e_busy;
  } vec_t;

  vec_t vt[11];

  initial begin
    // inputs: mpx cpu mv lb mb start first last | expect: rdy stall grant mv io mb lb done busy
    vt[0]  = '{1'b0,1'b1,2'd1,2'd2,2'd3,1'b0,2'd0,2'd0, 1'b0,1'b0,2'd2,2'd1,1'b0,2'd3,2'd2,1'b0,1'b0};
    vt[1]  = '{1'b0,1'b0,2'd0,2'd0,2'd0,1'b0,2'd0,2'd0, 1'b0,1'b0,2'd0,2'd0,1'b0,2'd3,2'd2,1'b0,1'b0};
    vt[2]  = '{1'b0,1'b0,2'd0,2'd0,2'd0,1'b1,2'd1,2'd2, 1'b0,1'b0,2'd0,2'd0,1'b0,2'd3,2'd2,1'b0,1'b1};
    vt[3]  = '{1'b0,1'b0,2'd0,2'd0,2'd0,1'b0,2'd0,2'd0, 1'b0,1'b0,2'd3,2'd2,1'b0,2'd1,2'd2,1'b0,1'b1};
    vt[4]  = '{1'b1,1'b1,2'd3,2'd0,2'd0,1'b0,2'd0,2'd0, 1'b1,1'b1,2'd1,2'd2,1'b1,2'd1,2'd2,1'b0,1'b1};
    vt[5]  = '{1'b0,1'b0,2'd0,2'd0,2'd0,1'b0,2'd0,2'd0, 1'b0,1'b0,2'd3,2'd2,1'b0,2'd2,2'd2,1'b1,1'b0};
    vt[6]  = '{1'b0,1'b0,2'd0,2'd0,2'd0,1'b0,2'd0,2'd0, 1'b0,1'b0,2'd0,2'd0,1'b0,2'd2,2'd2,1'b0,1'b0};
    vt[7]  = '{1'b0,1'b0,2'd0,2'd0,2'd0,1'b1,2'd3,2'd0, 1'b0,1'b0,2'd0,2'd0,1'b0,2'd2,2'd2,1'b0,1'b1};
    vt[8]  = '{1'b0,1'b0,2'd0,2'd0,2'd0,1'b0,2'd0,2'd0, 1'b0,1'b0,2'd3,2'd2,1'b0,2'd3,2'd2,1'b0,1'b1};
    vt[9]  = '{1'b0,1'b0,2'd0,2'd0,2'd0,1'b1,2'd1,2'd1, 1'b0,1'b0,2'd3,2'd2,1'b0,2'd0,2'd2,1'b1,1'b0};
    vt[10] = '{1'b0,1'b0,2'd0,2'd0,2'd0,1'b0,2'd0,2'd0, 1'b0,1'b0,2'd0,2'd0,1'b0,2'd0,2'd2,1'b0,1'b0};

    rst_n = 1'b0;
    mpx_valid = 0; cpu_req = 0; cpu_mv = 0; cpu_lb = 0; cpu_mb = 0;
    str_start = 0; str_first = 0; str_last = 0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk_all_zero("reset");
    rst_n = 1'b1;

    for (int k = 0; k < 11; k++) begin
      step(vt[k].mpx, vt[k].cpu, vt[k].mv, vt[k].lb, vt[k].mb, vt[k].st, vt[k].fi, vt[k].la);
      chk($sformatf("vec%0d_ready", k), int'(smp_ready), int'(vt[k].e_rdy));
      chk($sformatf("vec%0d_stall", k), int'(smp_stall), int'(vt[k].e_stall));
      chk($sformatf("vec%0d_grant", k), int'(grant), int'(vt[k].e_grant));
      chk($sformatf("vec%0d_mv", k), int'(mv), int'(vt[k].e_mv));
      chk($sformatf("vec%0d_io", k), int'(io_mode), int'(vt[k].e_io));
      chk($sformatf("vec%0d_mb", k), int'(mb), int'(vt[k].e_mb));
      chk($sformatf("vec%0d_lb", k), int'(lb), int'(vt[k].e_lb));
      chk($sformatf("vec%0d_done", k), int'(str_done), int'(vt[k].e_done));
      chk($sformatf("vec%0d_busy", k), int'(str_busy), int'(vt[k].e_busy));
    end

    // Constant mpx traffic against a waiting CPU: four mpx beats then one CPU slot.
    for (int i = 0; i < 15; i++) begin
      step(1'b1, 1'b1, 2'd3, 2'd1, 2'd2, 1'b0, 2'd0, 2'd0);
      chk($sformatf("burst%0d_ready", i), int'(smp_ready), int'((i % 5) != 4));
      chk($sformatf("burst%0d_grant", i), int'(grant), ((i % 5) == 4) ? 2 : 1);
      if ((i % 5) == 4) chk($sformatf("burst%0d_mv", i), int'(mv), 3);
    end

    // Mid-stream asynchronous reset.
    step(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b1, 2'd0, 2'd3);
    step(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0);
    chk("midrst_pre_busy", int'(str_busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    chk_all_zero("midrst_hold");
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0);

    // Random traffic, alternating heavy and light load so streams get to finish.
    for (int i = 0; i < 600; i++) begin
      bit heavy;
      logic m, c, s;
      heavy = ((i / 60) % 2) == 0;
      m = ($urandom_range(0, 99) < (heavy ? 70 : 25));
      c = ($urandom_range(0, 99) < (heavy ? 50 : 15));
      s = ($urandom_range(0, 99) < 20);
      step(m, c, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
           s, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
